// File: rtl/hex_display_arbiter_if.sv
// hex_display_arbiter_if: request/data/grant bundle between three requesters and the display arbiter
//   master: drives req, data0..data2; observes grant, num, scan_clk
//   slave : the arbiter; observes req, data0..data2; drives grant, num, scan_clk
interface hex_display_arbiter_if;
    logic [2:0]  req;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [15:0] data2;
    logic [2:0]  grant;
    logic [15:0] num;
    logic        scan_clk;
    modport master (output req, data0, data1, data2, input grant, num, scan_clk);
    modport slave  (input req, data0, data1, data2, output grant, num, scan_clk);
endinterface

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: round-robin owner of the 4-digit hex display with minimum hold time, plus scan clock divider
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : hex_display_arbiter_if.slave (req, data0..2 in; grant, num, scan_clk out)
//   HEX_ARB_ID_DIGIT_EN : when defined, num[15:12] shows owner index + 1
module hex_display_arbiter #(
    parameter int          SCAN_DIV    = 25000,
    parameter int          HOLD_CYCLES = 50000000,
    parameter logic [15:0] IDLE_VALUE  = 16'h0000
) (
    input logic clk,
    input logic rst,
    hex_display_arbiter_if.slave bus
);
    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DIV_MAX  = DW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
`ifdef HEX_ARB_ID_DIGIT_EN
    localparam logic [15:0] IDLE_NUM = {4'h0, IDLE_VALUE[11:0]};
`else
    localparam logic [15:0] IDLE_NUM = IDLE_VALUE;
`endif

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state;
    logic [1:0]    last;
    logic [HW-1:0] hold_cnt;
    logic [DW-1:0] div_cnt;
    logic [2:0]    grant_r;
    logic [15:0]   num_r;
    logic          scan_r;
    logic [2:0]    others;
    logic [1:0]    win_idle;
    logic [1:0]    win_hand;

    function automatic logic [1:0] after(input logic [1:0] k);
        return k == 2'd2 ? 2'd0 : k + 2'd1;
    endfunction

    // First set bit of r searching from k+1 round the ring; k itself is the last candidate.
    function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] k);
        logic [1:0] a;
        logic [1:0] b;
        a = after(k);
        b = after(a);
        return r[a] ? a : r[b] ? b : k;
    endfunction

    function automatic logic [15:0] shown(input logic [1:0] k);
        logic [15:0] d;
        d = k == 2'd0 ? bus.data0 : k == 2'd1 ? bus.data1 : bus.data2;
`ifdef HEX_ARB_ID_DIGIT_EN
        return {2'b00, k + 2'd1, d[11:0]};
`else
        return d;
`endif
    endfunction

    // In OWN, last is the current owner.
    assign others   = bus.req & ~(3'b001 << last);
    assign win_idle = pick(bus.req, last);
    assign win_hand = pick(others, last);

    assign bus.grant    = grant_r;
    assign bus.num      = num_r;
    assign bus.scan_clk = scan_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            scan_r  <= 1'b0;
        end else if (div_cnt == DIV_MAX) begin
            div_cnt <= '0;
            scan_r  <= ~scan_r;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 2'd2;
            hold_cnt <= '0;
            grant_r  <= 3'b000;
            num_r    <= IDLE_NUM;
        end else if (state == IDLE) begin
            if (|bus.req) begin
                state    <= OWN;
                last     <= win_idle;
                hold_cnt <= '0;
                grant_r  <= 3'b001 << win_idle;
                num_r    <= shown(win_idle);
            end
        end else if (!bus.req[last]) begin
            state    <= IDLE;
            hold_cnt <= '0;
            grant_r  <= 3'b000;
            num_r    <= IDLE_NUM;
        end else if (hold_cnt == HOLD_MAX && |others) begin
            last     <= win_hand;
            hold_cnt <= '0;
            grant_r  <= 3'b001 << win_hand;
            num_r    <= shown(win_hand);
        end else begin
            hold_cnt <= hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + HW'(1);
            num_r    <= shown(last);
        end
    end
endmodule

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Shares the single 4-digit hex LED display between three requesters, for example the serial transceiver's TX byte, RX byte and status word. The block grants the display round-robin, with a minimum hold time per grant, and registers the selected 16-bit value as `num` for the display driver. It also generates the slow scan clock that drives the display driver's digit multiplexing.

## Interface
- `SCAN_DIV`, default 25000: `scan_clk` half-period in `clk` cycles; legal range ≥1.
- `HOLD_CYCLES`, default 50000000: minimum grant duration in `clk` cycles; legal range ≥1.
- `IDLE_VALUE`, default 16'h0000: `num` value while no grant is active.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  3  level request per requester; bit i belongs to requester i.
- `data0`, `data1`, `data2`  in  16 each  value offered by each requester.
- `grant`  out  3  one-hot or zero; shows the current owner.
- `num`  out  16  registered value for the display driver.
- `scan_clk`  out  1  divided clock (50% duty) for the display driver.

## Operation
- Scan divider:
  - `div_cnt` counts 0..SCAN_DIV-1.
  - On reaching SCAN_DIV-1, `div_cnt` wraps to 0 and `scan_clk` toggles.
  - Period = 2·SCAN_DIV `clk` cycles.
  - The divider free-runs and is independent of arbitration.
- FSM states: IDLE and OWN.
- IDLE:
  - `grant`=0 and `num`=IDLE_VALUE.
  - If any `req` bit is set, pick the winner by round-robin starting at index `last`+1 mod 3.
  - Go to OWN: set the winner's `grant` bit, load `last`=winner, clear `hold_cnt`.
- OWN with owner k:
  - `hold_cnt` increments each cycle and saturates at HOLD_CYCLES-1.
  - `num` ← `data_k` every cycle, so it tracks live data.
- Leaving OWN, in priority order:
  - `req[k]`=0: go to IDLE next cycle regardless of `hold_cnt`. The early release is a voluntary release.
  - `hold_cnt`=HOLD_CYCLES-1 and another `req` bit is set: hand over directly to the next requester in round-robin order after k.
    - The new owner is granted in the same edge, with no IDLE gap.
    - `hold_cnt` clears and `last` is updated.
  - `hold_cnt` saturated and no other request: stay in OWN with k indefinitely.
- Round-robin order is 0→1→2→0. A requester never gets two consecutive expiry handovers while others are waiting.
- Simultaneous requests in IDLE are resolved by the `last` pointer only.
- Reset mid-grant aborts immediately, with no handshake toward the requester.
- `grant` is never multi-hot. `num` always equals either IDLE_VALUE or the owner's data.

## Timing
- Reset values:
  - `grant`=3'b000, `num`=IDLE_VALUE, `scan_clk`=0.
  - `div_cnt`=0, `hold_cnt`=0, `last`=2, so requester 0 wins first. State=IDLE.
- Request latency: with `req` asserted in cycle n while IDLE, `grant` is set after edge n+1. `num` shows the owner's data after the same edge, because `num` is loaded from the winner in the transition cycle.
- Data latency while owning: 1 cycle from `data_k` to `num`.
- Release latency: with `req[k]` deasserted in cycle n, `grant`=0 and `num`=IDLE_VALUE after edge n+1.
- Expiry handover: occurs on the edge where `hold_cnt`=HOLD_CYCLES-1. The minimum tenure is therefore exactly HOLD_CYCLES cycles.
- First `scan_clk` rise occurs SCAN_DIV cycles after reset release.

## Configuration
- `HEX_ARB_ID_DIGIT_EN` defined:
  - `num[15:12]` is replaced with the owner index plus 1 (values 1..3).
  - `num[11:0]` comes from `data_k[11:0]`.
  - In IDLE, `num` = {4'h0, IDLE_VALUE[11:0]}.
- Not defined: `num` carries the full 16-bit `data_k`, or IDLE_VALUE in IDLE.

## Test plan
Test parameters: SCAN_DIV=4, HOLD_CYCLES=8.
- Reset check: assert `rst` mid-stream. Required response: `grant`=0, `num`=0000 and `scan_clk`=0 immediately, without waiting for a clock edge. After release, `scan_clk` toggles every 4 cycles.
- Single requester: `req`=001 and `data0`=1234.
  - Next edge: `grant`=001 and `num`=1234.
  - Change `data0` to ABCD: `num`=ABCD one cycle later.
  - Drop `req`: `grant`=000 and `num`=0000 next cycle.
- Simultaneous requests from reset: `req`=111 held.
  - `grant` sequence is 001, 010, 100, 001, with each owner held for exactly 8 cycles.
  - There are no idle gaps between owners.
- Early release: owner 1 drops `req` after 3 cycles while `req[2]` is set. Required response: IDLE for one cycle, then `grant`=100.
- Sole requester past expiry: `req`=010 held for 30 cycles. Required response: `grant` stays 010 throughout and `num` keeps tracking `data1`.
- With `HEX_ARB_ID_DIGIT_EN` defined: owner 2 with `data2`=FFFF gives `num`=3FFF; IDLE gives `num`=0000.
